mem_access_stage: RTL and testbench
===================================

// Module: mem_access_stage
// PURPOSE
//  MIPS pipeline MEM stage: sits between the EX/MEM register and the MEM/WB register.
//  Turns load/store control plus the ALU address into a req/ack data-memory transaction.
//  Handles byte/half/word lane alignment and stalls the pipeline until memory answers.
//  Load data (rd_out) feeds MEM/WB RD_in. A watchdog aborts transactions that memory never acks.
// PARAMETERS
//  TIMEOUT_CYC  255  max BUSY cycles waiting for dmem_ack; 0 = watchdog disabled
// PORTS
//  clk          in   1   clock, rising edge
//  rst          in   1   synchronous, active-high reset
//  valid_in     in   1   EX/MEM holds a valid instruction
//  mem_read_in  in   1   load
//  mem_write_in in   1   store (priority over mem_read_in when both set)
//  size_in      in   2   00 byte, 01 half, 10 word, 11 reserved (= word)
//  sign_in      in   1   load sign-extend (LB/LH) vs zero-extend (LBU/LHU)
//  addr_in      in   32  byte address (ALU result)
//  wdata_in     in   32  store data (rt)
//  stall        out  1   freeze PC/IF/ID/EX/MEM regs and hold MEM/WB capture
//  dmem_req     out  1   memory request, held until ack/abort
//  dmem_we      out  1   1 = write
//  dmem_addr    out  32  {addr[31:2],2'b00}
//  dmem_be      out  4   byte enables, little-endian
//  dmem_wdata   out  32  lane-replicated store data
//  dmem_ack     in   1   memory done; rdata valid same cycle
//  dmem_rdata   in   32  read word
//  rd_out       out  32  aligned/extended load data
//  bus_err      out  1   one-cycle pulse: watchdog abort
//  align_err    out  1   one-cycle pulse: misaligned access (0 without macro)
// BEHAVIOUR
//  Reset: state IDLE; stall, dmem_req, dmem_we, bus_err, align_err = 0; dmem_addr/be/wdata, rd_out, counter = 0.
//  rst in any state (incl. BUSY) abandons the transaction: req drops next cycle; memory tolerates it.
//  FSM IDLE -> BUSY -> DONE -> IDLE.
//  IDLE: acc = valid_in & (mem_read_in|mem_write_in). stall = acc (combinational).
//   If acc: latch addr/be/wdata/size/sign/we; go BUSY. Else rd_out = 0, no stall.
//  BUSY: dmem_req=1, stall=1, outputs stable; count++.
//   dmem_ack -> latch aligned load (store: 0) into rd_q; go DONE.
//   count==TIMEOUT_CYC (TIMEOUT_CYC!=0) with no ack -> rd_q=0, set bus_err; go DONE.
//  DONE: stall=0, rd_out=rd_q, bus_err pulse; MEM/WB captures; unconditional -> IDLE.
//  Latency: ack in first BUSY cycle => stall 2 cycles, result in cycle 3.
//  dmem_ack outside BUSY is ignored.
//  Lanes: byte be=0001<<a[1:0], wdata={4{w[7:0]}}; half be=0011<<{a[1],0}, wdata={2{w[15:0]}}; word be=1111.
//  Load: shift rdata right by 8*a[1:0] (half: 16*a[1]); extend from bit 7/15 per sign_in.
// CONFIGURATION
//  MEM_ALIGN_CHK_EN defined: half with a[0]=1 or word with a[1:0]!=0 issues no req.
//   IDLE -> DONE directly, rd_q=0, align_err pulses in DONE (stall 1 cycle).
//  Not defined: align_err tied 0; low address bits ignored (half uses a[1], word none); access proceeds.
// STRUCTURE
//  Package mips_mem_pkg: SZ_BYTE/SZ_HALF/SZ_WORD encodings, state enum {IDLE,BUSY,DONE}.
//  Sub-module mem_load_align: combinational lane select + sign/zero extend (rdata, a[1:0], size, sign -> 32b).
// TESTING
//  LW a=0x10, ack 2 cycles after req with rdata 0xDEADBEEF -> dmem_addr 0x10, be 1111, stall 3 cycles, rd_out 0xDEADBEEF.
//  LB a=0x13, rdata 0x80FF0000 -> be 1000, rd_out 0xFFFFFF80; same as LBU -> 0x00000080.
//  SH a=0x6, wdata 0x1234ABCD -> dmem_we 1, be 1100, dmem_wdata 0xABCDABCD, rd_out 0.
//  TIMEOUT_CYC=4, no ack -> req drops after 4 BUSY cycles, bus_err 1 cycle, rd_out 0, stall released.
//  rst during BUSY -> next cycle req 0, stall 0, IDLE; following LW completes normally.
//  LW a=0x2: macro on -> no req, align_err 1 cycle; macro off -> req to 0x0, be 1111.

Source files
------------

// File: rtl/mips_mem_pkg.sv
// Shared encodings for the MIPS MEM stage: access sizes, FSM states and lane helpers.
package mips_mem_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        BUSY = 2'b01,
        DONE = 2'b10
    } state_e;

    // Size code 2'b11 is reserved and behaves as a full word.
    function automatic logic [3:0] lane_be(input logic [1:0] size, input logic [1:0] off);
        case (size)
            SZ_BYTE: return 4'b0001 << off;
            SZ_HALF: return 4'b0011 << {off[1], 1'b0};
            default: return 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] lane_wdata(input logic [1:0] size, input logic [31:0] w);
        case (size)
            SZ_BYTE: return {4{w[7:0]}};
            SZ_HALF: return {2{w[15:0]}};
            default: return w;
        endcase
    endfunction

endpackage

// File: rtl/mem_load_align.sv
// Load lane select: shifts the addressed byte/half down to bit 0 and sign- or zero-extends it.
module mem_load_align
    import mips_mem_pkg::*;
(
    input  logic [31:0] rdata_i,
    input  logic [1:0]  off_i,
    input  logic [1:0]  size_i,
    input  logic        sign_i,
    output logic [31:0] data_o
);

    logic [31:0] byte_sh;
    logic [31:0] half_sh;

    assign byte_sh = rdata_i >> {off_i, 3'b000};
    assign half_sh = rdata_i >> {off_i[1], 4'b0000};

    always_comb begin
        data_o = rdata_i;
        case (size_i)
            SZ_BYTE: data_o = {{24{sign_i & byte_sh[7]}}, byte_sh[7:0]};
            SZ_HALF: data_o = {{16{sign_i & half_sh[15]}}, half_sh[15:0]};
            default: data_o = rdata_i;
        endcase
    end

endmodule

// File: rtl/mem_access_stage.sv
// MIPS MEM stage: turns load/store control into a req/ack memory transaction with a watchdog.
// Optional misalignment trap enabled by defining MEM_ALIGN_CHK_EN.
module mem_access_stage
    import mips_mem_pkg::*;
#(
    parameter int TIMEOUT_CYC = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        valid_in,
    input  logic        mem_read_in,
    input  logic        mem_write_in,
    input  logic [1:0]  size_in,
    input  logic        sign_in,
    input  logic [31:0] addr_in,
    input  logic [31:0] wdata_in,
    output logic        stall,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [3:0]  dmem_be,
    output logic [31:0] dmem_wdata,
    input  logic        dmem_ack,
    input  logic [31:0] dmem_rdata,
    output logic [31:0] rd_out,
    output logic        bus_err,
    output logic        align_err
);

    localparam int CW = (TIMEOUT_CYC < 2) ? 1 : $clog2(TIMEOUT_CYC + 1);
    localparam logic [CW:0] TO_LIM = (CW + 1)'(TIMEOUT_CYC);

    state_e      state_q, state_d;
    logic [31:0] addr_q, addr_d;
    logic [1:0]  off_q, off_d;
    logic [3:0]  be_q, be_d;
    logic [31:0] wdata_q, wdata_d;
    logic        we_q, we_d;
    logic [1:0]  size_q, size_d;
    logic        sign_q, sign_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [31:0] rd_q, rd_d;
    logic        berr_q, berr_d;
    logic        aerr_q, aerr_d;

    logic        acc;
    logic        misalign;
    logic        timeout_hit;
    logic [CW:0] cnt_inc;
    logic [31:0] load_data;

    assign acc = valid_in & (mem_read_in | mem_write_in);

`ifdef MEM_ALIGN_CHK_EN
    assign misalign = ((size_in == SZ_HALF) && addr_in[0]) ||
                      (size_in[1] && (addr_in[1:0] != 2'b00));
`else
    assign misalign = 1'b0;
`endif

    // Watchdog fires on the BUSY cycle that would make the count reach the limit.
    assign cnt_inc     = {1'b0, cnt_q} + 1'b1;
    assign timeout_hit = (TIMEOUT_CYC != 0) && (cnt_inc == TO_LIM);

    mem_load_align u_align (
        .rdata_i (dmem_rdata),
        .off_i   (off_q),
        .size_i  (size_q),
        .sign_i  (sign_q),
        .data_o  (load_data)
    );

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        off_d   = off_q;
        be_d    = be_q;
        wdata_d = wdata_q;
        we_d    = we_q;
        size_d  = size_q;
        sign_d  = sign_q;
        cnt_d   = cnt_q;
        rd_d    = rd_q;
        berr_d  = 1'b0;
        aerr_d  = 1'b0;
        stall   = 1'b0;
        case (state_q)
            IDLE: begin
                stall = acc;
                if (acc) begin
                    addr_d  = {addr_in[31:2], 2'b00};
                    off_d   = addr_in[1:0];
                    be_d    = lane_be(size_in, addr_in[1:0]);
                    wdata_d = lane_wdata(size_in, wdata_in);
                    we_d    = mem_write_in;
                    size_d  = size_in;
                    sign_d  = sign_in;
                    cnt_d   = '0;
                    rd_d    = '0;
                    if (misalign) begin
                        aerr_d  = 1'b1;
                        state_d = DONE;
                    end else begin
                        state_d = BUSY;
                    end
                end
            end
            BUSY: begin
                stall = 1'b1;
                cnt_d = cnt_inc[CW-1:0];
                if (dmem_ack) begin
                    rd_d    = we_q ? 32'h0 : load_data;
                    state_d = DONE;
                end else if (timeout_hit) begin
                    rd_d    = 32'h0;
                    berr_d  = 1'b1;
                    state_d = DONE;
                end
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            addr_q  <= '0;
            off_q   <= '0;
            be_q    <= '0;
            wdata_q <= '0;
            we_q    <= 1'b0;
            size_q  <= '0;
            sign_q  <= 1'b0;
            cnt_q   <= '0;
            rd_q    <= '0;
            berr_q  <= 1'b0;
            aerr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            off_q   <= off_d;
            be_q    <= be_d;
            wdata_q <= wdata_d;
            we_q    <= we_d;
            size_q  <= size_d;
            sign_q  <= sign_d;
            cnt_q   <= cnt_d;
            rd_q    <= rd_d;
            berr_q  <= berr_d;
            aerr_q  <= aerr_d;
        end
    end

    // Error flags are set on the transition into DONE, so they last exactly that cycle.
    assign dmem_req   = (state_q == BUSY);
    assign dmem_we    = (state_q == BUSY) & we_q;
    assign dmem_addr  = addr_q;
    assign dmem_be    = be_q;
    assign dmem_wdata = wdata_q;
    assign rd_out     = (state_q == DONE) ? rd_q : 32'h0;
    assign bus_err    = berr_q;
    assign align_err  = aerr_q;

endmodule

// File: tb/tb_mem_access_stage.sv
// Scoreboard bench for mem_access_stage: driver pushes expected responses, monitor checks them.
module tb_mem_access_stage;
    import mips_mem_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        valid_in = 1'b0;
    logic        mem_read_in = 1'b0;
    logic        mem_write_in = 1'b0;
    logic [1:0]  size_in = 2'b00;
    logic        sign_in = 1'b0;
    logic [31:0] addr_in = 32'h0;
    logic [31:0] wdata_in = 32'h0;
    logic        dmem_ack = 1'b0;
    logic [31:0] dmem_rdata = 32'h0;
    logic        stall, dmem_req, dmem_we, bus_err, align_err;
    logic [31:0] dmem_addr, dmem_wdata, rd_out;
    logic [3:0]  dmem_be;

    mem_access_stage #(.TIMEOUT_CYC(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .valid_in   (valid_in),
        .mem_read_in(mem_read_in),
        .mem_write_in(mem_write_in),
        .size_in    (size_in),
        .sign_in    (sign_in),
        .addr_in    (addr_in),
        .wdata_in   (wdata_in),
        .stall      (stall),
        .dmem_req   (dmem_req),
        .dmem_we    (dmem_we),
        .dmem_addr  (dmem_addr),
        .dmem_be    (dmem_be),
        .dmem_wdata (dmem_wdata),
        .dmem_ack   (dmem_ack),
        .dmem_rdata (dmem_rdata),
        .rd_out     (rd_out),
        .bus_err    (bus_err),
        .align_err  (align_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          id;
        logic        has_req;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic        we;
        logic [31:0] rd;
        logic        berr;
        logic        aerr;
        int          stall_cyc;
        logic        aborted;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   failures = 0;
    int   idle_mode = 0;
    logic end_chk = 1'b0;
    logic mon_done = 1'b0;

    function automatic exp_t mk(input int id, input logic hr, input logic [31:0] a,
                                input logic [3:0] be, input logic [31:0] wd, input logic we,
                                input logic [31:0] rd, input logic berr, input logic aerr,
                                input int st, input logic ab);
        exp_t e;
        e.id = id; e.has_req = hr; e.addr = a; e.be = be; e.wdata = wd; e.we = we;
        e.rd = rd; e.berr = berr; e.aerr = aerr; e.stall_cyc = st; e.aborted = ab;
        return e;
    endfunction

    // Memory responder: acks after dly BUSY cycles (dly < 0 never acks).
    task automatic txn(input exp_t e, input logic w, input logic r, input logic [1:0] sz,
                       input logic sg, input logic [31:0] a, input logic [31:0] wd,
                       input logic [31:0] rdat, input int dly);
        int busy_i = 0;
        exp_q.push_back(e);
        @(posedge clk); #1;
        valid_in = 1'b1; mem_write_in = w; mem_read_in = r; size_in = sz;
        sign_in = sg; addr_in = a; wdata_in = wd; dmem_rdata = rdat;
        for (int g = 0; g < 40; g++) begin
            @(posedge clk); #1;
            dmem_ack = 1'b0;
            if (!stall) begin
                valid_in = 1'b0; mem_read_in = 1'b0; mem_write_in = 1'b0;
                return;
            end
            if (dmem_req) begin
                dmem_ack = (busy_i == dly);
                busy_i++;
            end
        end
        $display("FAIL txn_bound id=%0d stall actual=1 required=0 within 40 cycles", e.id);
        $fatal(1, "transaction did not complete");
    endtask

    // Monitor: owns the check counters.
    exp_t cur;
    logic have_cur = 1'b0;
    int   nstall = 0;
    logic req_seen = 1'b0;
    logic stall_prev = 1'b0;
    logic req_prev = 1'b0;
    logic post_chk = 1'b0;

    task automatic chk(input string nm, input int id, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s id=%0d actual=0x%08h required=0x%08h", nm, id, act, req);
        end
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (idle_mode != 0) begin
                chk("idle_stall", 0, {31'b0, stall}, 32'h0);
                chk("idle_req", 0, {31'b0, dmem_req}, 32'h0);
                chk("idle_errs", 0, {30'b0, bus_err, align_err}, 32'h0);
                chk("idle_rd_out", 0, rd_out, 32'h0);
                if (idle_mode == 1) begin
                    chk("rst_we", 0, {31'b0, dmem_we}, 32'h0);
                    chk("rst_addr", 0, dmem_addr, 32'h0);
                    chk("rst_be", 0, {28'b0, dmem_be}, 32'h0);
                    chk("rst_wdata", 0, dmem_wdata, 32'h0);
                end
            end
            if (post_chk) begin
                post_chk = 1'b0;
                chk("pulse_end", cur.id, {30'b0, bus_err, align_err}, 32'h0);
                chk("rd_out_idle", cur.id, rd_out, 32'h0);
            end
            if (stall && !stall_prev) begin
                nstall = 0;
                req_seen = 1'b0;
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    have_cur = 1'b0;
                    $display("FAIL unexpected_stall actual=1 required=0");
                end else begin
                    cur = exp_q.pop_front();
                    have_cur = 1'b1;
                end
            end
            if (stall) nstall++;
            if (dmem_req && !req_prev && have_cur) begin
                req_seen = 1'b1;
                chk("dmem_addr", cur.id, dmem_addr, cur.addr);
                chk("dmem_be", cur.id, {28'b0, dmem_be}, {28'b0, cur.be});
                chk("dmem_wdata", cur.id, dmem_wdata, cur.wdata);
                chk("dmem_we", cur.id, {31'b0, dmem_we}, {31'b0, cur.we});
            end
            if (!stall && stall_prev && have_cur) begin
                chk("req_issued", cur.id, {31'b0, req_seen}, {31'b0, cur.has_req});
                chk("rd_out", cur.id, rd_out, cur.rd);
                chk("bus_err", cur.id, {31'b0, bus_err}, {31'b0, cur.berr});
                chk("align_err", cur.id, {31'b0, align_err}, {31'b0, cur.aerr});
                chk("req_dropped", cur.id, {31'b0, dmem_req}, 32'h0);
                if (!cur.aborted)
                    chk("stall_cycles", cur.id, 32'(nstall), 32'(cur.stall_cyc));
                have_cur = 1'b0;
                post_chk = 1'b1;
            end
            if (end_chk && !mon_done) begin
                chk("pending_expect", 0, 32'(exp_q.size()), 32'h0);
                mon_done = 1'b1;
            end
            stall_prev = stall;
            req_prev = dmem_req;
        end
    end

    initial begin
        idle_mode = 1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        idle_mode = 0;

        // id, has_req, addr, be, wdata, we, rd, bus_err, align_err, stall, aborted
        txn(mk(1, 1, 32'h10, 4'hF, 32'h0, 0, 32'hDEADBEEF, 0, 0, 3, 0), 0, 1, SZ_WORD, 0, 32'h10, 32'h0, 32'hDEADBEEF, 1);
        txn(mk(2, 1, 32'h10, 4'h8, 32'h0, 0, 32'hFFFFFF80, 0, 0, 2, 0), 0, 1, SZ_BYTE, 1, 32'h13, 32'h0, 32'h80FF0000, 0);
        txn(mk(3, 1, 32'h10, 4'h8, 32'h0, 0, 32'h00000080, 0, 0, 2, 0), 0, 1, SZ_BYTE, 0, 32'h13, 32'h0, 32'h80FF0000, 0);
        txn(mk(4, 1, 32'h4, 4'hC, 32'hABCDABCD, 1, 32'h0, 0, 0, 2, 0), 1, 0, SZ_HALF, 0, 32'h6, 32'h1234ABCD, 32'hFFFFFFFF, 0);
        txn(mk(5, 1, 32'h0, 4'hC, 32'h0, 0, 32'hFFFF8001, 0, 0, 2, 0), 0, 1, SZ_HALF, 1, 32'h2, 32'h0, 32'h80011234, 0);
        txn(mk(6, 1, 32'h0, 4'h3, 32'h0, 0, 32'h0000F00D, 0, 0, 2, 0), 0, 1, SZ_HALF, 0, 32'h0, 32'h0, 32'h8001F00D, 0);
        txn(mk(7, 1, 32'h4, 4'h2, 32'hA5A5A5A5, 1, 32'h0, 0, 0, 3, 0), 1, 0, SZ_BYTE, 0, 32'h5, 32'h000000A5, 32'h0, 1);
        txn(mk(8, 1, 32'h10, 4'h2, 32'h0, 0, 32'h0000007F, 0, 0, 4, 0), 0, 1, SZ_BYTE, 1, 32'h11, 32'h0, 32'h00007F00, 2);
        txn(mk(9, 1, 32'h20, 4'hF, 32'hCAFEF00D, 1, 32'h0, 0, 0, 2, 0), 1, 1, SZ_WORD, 0, 32'h20, 32'hCAFEF00D, 32'h12345678, 0);
        txn(mk(10, 1, 32'h40, 4'hF, 32'h0, 0, 32'h0, 1, 0, 5, 0), 0, 1, SZ_WORD, 0, 32'h40, 32'h0, 32'hFFFFFFFF, -1);
        txn(mk(13, 1, 32'h30, 4'hF, 32'h0, 0, 32'h0BADF00D, 0, 0, 2, 0), 0, 1, 2'b11, 1, 32'h30, 32'h0, 32'h0BADF00D, 0);

        // Idle: valid without load/store, and a stray ack, must not stall or produce data.
        @(posedge clk); #1;
        idle_mode = 2;
        valid_in = 1'b1;
        dmem_ack = 1'b1;
        dmem_rdata = 32'h77777777;
        repeat (3) @(posedge clk);
        #1;
        valid_in = 1'b0;
        dmem_ack = 1'b0;
        idle_mode = 0;

        // Reset in the middle of BUSY abandons the transaction.
        exp_q.push_back(mk(11, 1, 32'h80, 4'hF, 32'h0, 0, 32'h0, 0, 0, 0, 1));
        @(posedge clk); #1;
        valid_in = 1'b1; mem_read_in = 1'b1; size_in = SZ_WORD; sign_in = 1'b0; addr_in = 32'h80;
        for (int g = 0; g <= 20; g++) begin
            if (g == 20) begin
                $display("FAIL rst_abort_req dmem_req actual=0 required=1 within 20 cycles");
                $fatal(1, "request never issued");
            end
            @(posedge clk); #1;
            if (dmem_req) break;
        end
        @(posedge clk); #1;
        rst = 1'b1; valid_in = 1'b0; mem_read_in = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;

        txn(mk(12, 1, 32'h10, 4'hF, 32'h0, 0, 32'h11223344, 0, 0, 2, 0), 0, 1, SZ_WORD, 0, 32'h10, 32'h0, 32'h11223344, 0);
`ifdef MEM_ALIGN_CHK_EN
        txn(mk(14, 0, 32'h0, 4'h0, 32'h0, 0, 32'h0, 0, 1, 1, 0), 0, 1, SZ_WORD, 0, 32'h2, 32'h0, 32'h55667788, 0);
`else
        txn(mk(14, 1, 32'h0, 4'hF, 32'h0, 0, 32'h55667788, 0, 0, 2, 0), 0, 1, SZ_WORD, 0, 32'h2, 32'h0, 32'h55667788, 0);
`endif

        repeat (3) @(posedge clk);
        end_chk = 1'b1;
        repeat (3) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
